// File: rtl/spi_regbank_slave.sv
// rtl/spi_regbank_slave.sv - SPI slave register bank (CPOL/CPHA, strobes, frame errors)
// Optional burst frames with auto-incrementing address when SPI_AUTOINC_EN is defined.
module spi_regbank_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int N_MOSI = 16,
    parameter int N_MISO = 16,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       SPI_CLK,
    input  logic                       SPI_CS,
    input  logic                       SPI_MOSI,
    output logic                       SPI_MISO,
    input  logic [N_MISO*DATA_W-1:0]   miso_regs,
    output logic [N_MOSI*DATA_W-1:0]   mosi_regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       rd_strobe,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic                       busy,
    output logic                       frame_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int   CNT_W     = $clog2(DATA_W + 1);
    localparam logic SCLK_IDLE = (CPOL != 0);

    logic [2:0]        r_sclk_sync;
    logic [2:0]        r_cs_sync;
    logic [1:0]        r_mosi_sync;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-2:0] r_rx;
    logic [DATA_W-1:0] r_tx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic              r_extra;
    logic              r_word_done;
    logic [DATA_W-1:0] r_mosi [N_MOSI];

    logic              w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;
    logic              w_cs_high, w_cs_fall, w_partial;
    logic [DATA_W-1:0] w_word;
    logic [ADDR_W-1:0] w_cmd_addr, w_snap_addr;
    logic [DATA_W-1:0] w_snap;

    assign w_rise    = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_fall    = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_lead    = SCLK_IDLE ? w_fall : w_rise;
    assign w_trail   = SCLK_IDLE ? w_rise : w_fall;
    assign w_sample  = (CPHA != 0) ? w_trail : w_lead;
    assign w_shift   = (CPHA != 0) ? w_lead : w_trail;
    assign w_cs_high = r_cs_sync[1];
    assign w_cs_fall = ~r_cs_sync[1] & r_cs_sync[2];

    assign w_word      = {r_rx, r_mosi_sync[1]};
    assign w_cmd_addr  = ADDR_W'({r_rx[6:0], r_mosi_sync[1]});
    // First snapshot comes from the command byte; burst refills read the next address.
    assign w_snap_addr = (r_state == S_CMD) ? w_cmd_addr : r_addr + ADDR_W'(1);

    assign w_partial = (r_state == S_CMD)
                     | ((r_state == S_DATA) & ((r_cnt != '0) | ~r_word_done))
                     | ((r_state == S_DONE) & r_extra);

    always_comb begin
        w_snap = '0;
        for (int i = 0; i < N_MISO; i++) begin
            if (int'(w_snap_addr) == i) w_snap = miso_regs[i*DATA_W +: DATA_W];
        end
    end

    for (genvar gi = 0; gi < N_MOSI; gi++) begin : g_flat
        assign mosi_regs[gi*DATA_W +: DATA_W] = r_mosi[gi];
    end

    // CS sync resets low so a CS held low across reset never looks like a fresh frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= {3{SCLK_IDLE}};
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], SPI_CLK};
            r_cs_sync   <= {r_cs_sync[1:0], SPI_CS};
            r_mosi_sync <= {r_mosi_sync[0], SPI_MOSI};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_extra     <= 1'b0;
            r_word_done <= 1'b0;
            SPI_MISO    <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            rd_strobe   <= 1'b0;
            rd_addr     <= '0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            for (int i = 0; i < N_MOSI; i++) r_mosi[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (w_shift && r_state != S_IDLE) begin
                SPI_MISO <= r_tx[DATA_W-1];
                r_tx     <= r_tx << 1;
            end
            if (w_cs_high) begin
                if (r_state != S_IDLE) frame_err <= w_partial;
                r_state  <= S_IDLE;
                busy     <= 1'b0;
                SPI_MISO <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_cs_fall) begin
                        r_state     <= S_CMD;
                        busy        <= 1'b1;
                        r_cnt       <= '0;
                        r_rx        <= '0;
                        r_tx        <= '0;
                        r_extra     <= 1'b0;
                        r_word_done <= 1'b0;
                        SPI_MISO    <= 1'b0;
                    end
                    S_CMD: if (w_sample) begin
                        r_rx  <= w_word[DATA_W-2:0];
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(7)) begin
                            r_cnt   <= '0;
                            r_state <= S_DATA;
                            r_addr  <= w_cmd_addr;
                            r_write <= r_rx[6];
                            if (!r_rx[6]) begin
                                r_tx      <= w_snap;
                                rd_strobe <= 1'b1;
                                rd_addr   <= w_snap_addr;
                            end
                        end
                    end
                    S_DATA: if (w_sample) begin
                        r_rx  <= w_word[DATA_W-2:0];
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            r_cnt <= '0;
                            for (int i = 0; i < N_MOSI; i++) begin
                                if (r_write && int'(r_addr) == i) r_mosi[i] <= w_word;
                            end
                            if (r_write && int'(r_addr) < N_MOSI) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= r_addr;
                            end
`ifdef SPI_AUTOINC_EN
                            r_addr      <= r_addr + ADDR_W'(1);
                            r_word_done <= 1'b1;
                            if (!r_write) begin
                                r_tx      <= w_snap;
                                rd_strobe <= 1'b1;
                                rd_addr   <= w_snap_addr;
                            end
`else
                            r_state <= S_DONE;
`endif
                        end
                    end
                    S_DONE: if (w_sample) r_extra <= 1'b1;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_regbank_slave.sv
// tb/tb_spi_regbank_slave.sv - scoreboard bench: four SPI modes plus a narrow (N=8) instance
module tb_spi_regbank_slave;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NI = 5;
    localparam int HALF = 6;
    localparam int EV_WR = 0, EV_RD = 1, EV_ERR = 2;
`ifdef SPI_AUTOINC_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct { int kind; int inst; int addr; logic [DW-1:0] data; } ev_t;
    typedef struct { int inst; logic [71:0] bits; } rx_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0]               sclk, cs, mosi, miso;
    logic [NI-1:0]               wr_s, rd_s, busy_v, ferr;
    logic [NI-1:0][AW-1:0]       wr_a, rd_a;
    logic [NI-1:0][16*DW-1:0]    miso_v;
    logic [NI-1:0][16*DW-1:0]    mosi_v;
    logic [8*DW-1:0]             mosi_small;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_regbank_slave #(.DATA_W(DW), .ADDR_W(AW), .N_MOSI(16), .N_MISO(16),
                            .CPOL(g / 2), .CPHA(g % 2)) u_dut (
            .clk(clk), .reset(reset), .SPI_CLK(sclk[g]), .SPI_CS(cs[g]),
            .SPI_MOSI(mosi[g]), .SPI_MISO(miso[g]), .miso_regs(miso_v[g]),
            .mosi_regs(mosi_v[g]), .wr_strobe(wr_s[g]), .wr_addr(wr_a[g]),
            .rd_strobe(rd_s[g]), .rd_addr(rd_a[g]), .busy(busy_v[g]), .frame_err(ferr[g]));
    end

    spi_regbank_slave #(.DATA_W(DW), .ADDR_W(AW), .N_MOSI(8), .N_MISO(8),
                        .CPOL(0), .CPHA(0)) u_small (
        .clk(clk), .reset(reset), .SPI_CLK(sclk[4]), .SPI_CS(cs[4]),
        .SPI_MOSI(mosi[4]), .SPI_MISO(miso[4]), .miso_regs(miso_v[4][8*DW-1:0]),
        .mosi_regs(mosi_small), .wr_strobe(wr_s[4]), .wr_addr(wr_a[4]),
        .rd_strobe(rd_s[4]), .rd_addr(rd_a[4]), .busy(busy_v[4]), .frame_err(ferr[4]));
    assign mosi_v[4] = {{(8*DW){1'b0}}, mosi_small};

    int n_chk = 0;
    int n_fail = 0;
    ev_t q_ev[$];
    rx_t q_rx[$];
    logic [DW-1:0] exp_mosi [NI][16];
    logic [71:0] mon_rx;
    int mon_rx_inst;
    event rx_ev;

    function automatic logic cpol_of(input int g); return (g == 2 || g == 3); endfunction
    function automatic logic cpha_of(input int g); return (g == 1 || g == 3); endfunction
    function automatic int nreg(input int g); return (g == 4) ? 8 : 16; endfunction
    function automatic logic [DW-1:0] rd_word(input int g, input int a);
        return (a >= nreg(g)) ? '0 : miso_v[g][a*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int k, input int g, input int a, input logic [DW-1:0] d);
        q_ev.push_back('{kind: k, inst: g, addr: a, data: d});
    endtask

    // Reference model: consequences of one frame derived from command, bit count and register contents.
    task automatic model_frame(input int g, input int nbits, input logic [71:0] tx);
        logic [7:0] cmd;
        logic [DW-1:0] w;
        logic [71:0] erx;
        int a, nw, rem, words, aa, k;
        bit err;
        erx = '0;
        if (nbits < 8) begin
            push_ev(EV_ERR, g, 0, '0);
        end else begin
            for (int j = 0; j < 8; j++) cmd[7-j] = tx[nbits-1-j];
            a = int'(cmd[3:0]);
            nw = (nbits - 8) / DW;
            rem = (nbits - 8) % DW;
            words = BURST ? nw : ((nw > 0) ? 1 : 0);
            err = BURST ? ((rem != 0) || (nw == 0)) : (nbits != 8 + DW);
            if (!cmd[7]) begin
                push_ev(EV_RD, g, a, '0);
                for (int i = 8; i < nbits; i++) begin
                    k = (i - 8) / DW;
                    if (BURST || k == 0) begin
                        w = rd_word(g, (a + k) % 16);
                        erx[nbits-1-i] = w[DW-1-((i-8)%DW)];
                    end
                end
            end
            for (int kk = 0; kk < words; kk++) begin
                aa = (a + kk) % 16;
                if (cmd[7]) begin
                    for (int j = 0; j < DW; j++) w[DW-1-j] = tx[nbits-1-(8+kk*DW+j)];
                    if (aa < nreg(g)) begin
                        exp_mosi[g][aa] = w;
                        push_ev(EV_WR, g, aa, w);
                    end
                end else if (BURST) begin
                    push_ev(EV_RD, g, (aa + 1) % 16, '0);
                end
            end
            if (err) push_ev(EV_ERR, g, 0, '0);
        end
        q_rx.push_back('{inst: g, bits: erx});
    endtask

    task automatic xfer(input int g, input int nbits, input logic [71:0] tx,
                        input int poke_bit, input int poke_addr);
        logic [71:0] rx;
        rx = '0;
        cs[g] = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == poke_bit) miso_v[g][poke_addr*DW +: DW] = '0;
            if (!cpha_of(g)) mosi[g] = tx[nbits-1-i];
            repeat (HALF) @(negedge clk);
            sclk[g] = ~cpol_of(g);
            if (cpha_of(g)) mosi[g] = tx[nbits-1-i];
            else rx = {rx[70:0], miso[g]};
            if (i == 4) check("busy_mid_frame", 64'(busy_v[g]), 64'd1);
            repeat (HALF) @(negedge clk);
            sclk[g] = cpol_of(g);
            if (cpha_of(g)) rx = {rx[70:0], miso[g]};
        end
        repeat (HALF) @(negedge clk);
        cs[g] = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        mon_rx = rx;
        mon_rx_inst = g;
        -> rx_ev;
    endtask

    task automatic run_frame(input int g, input int nbits, input logic [71:0] tx,
                             input int poke_bit, input int poke_addr);
        model_frame(g, nbits, tx);
        xfer(g, nbits, tx, poke_bit, poke_addr);
    endtask

    task automatic check_ev(input int k, input int g, input int a, input logic [DW-1:0] d);
        ev_t e;
        n_chk++;
        if (q_ev.size() == 0) begin
            n_fail++;
            $display("FAIL event: unexpected kind %0d inst %0d addr %0d data %h, none expected", k, g, a, d);
        end else begin
            e = q_ev.pop_front();
            if (e.kind != k || e.inst != g || e.addr != a || (k == EV_WR && e.data !== d)) begin
                n_fail++;
                $display("FAIL event: got kind %0d inst %0d addr %0d data %h expected kind %0d inst %0d addr %0d data %h",
                         k, g, a, d, e.kind, e.inst, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (wr_s[g]) check_ev(EV_WR, g, int'(wr_a[g]), mosi_v[g][int'(wr_a[g])*DW +: DW]);
            if (rd_s[g]) check_ev(EV_RD, g, int'(rd_a[g]), '0);
            if (ferr[g]) check_ev(EV_ERR, g, 0, '0);
        end
    end

    always begin
        rx_t r;
        @(rx_ev);
        n_chk++;
        if (q_rx.size() == 0) begin
            n_fail++;
            $display("FAIL miso_word: inst %0d got %h, none expected", mon_rx_inst, mon_rx);
        end else begin
            r = q_rx.pop_front();
            if (r.inst != mon_rx_inst || r.bits !== mon_rx) begin
                n_fail++;
                $display("FAIL miso_word: inst %0d got %h expected inst %0d %h", mon_rx_inst, mon_rx, r.inst, r.bits);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check_idle_outputs(input string name, input int g);
        check(name, {57'd0, busy_v[g], wr_s[g], rd_s[g], ferr[g], miso[g], |mosi_v[g], |{wr_a[g], rd_a[g]}}, 64'd0);
    endtask

    initial begin
        int g, nbits, sel;
        logic [71:0] tx;
        for (int i = 0; i < NI; i++) begin
            sclk[i] = cpol_of(i);
            cs[i] = 1'b1;
            mosi[i] = 1'b0;
            for (int w = 0; w < 16; w++) begin
                miso_v[i][w*DW +: DW] = $urandom;
                exp_mosi[i][w] = '0;
            end
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < NI; i++) check_idle_outputs("reset_state", i);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int m = 0; m < 4; m++) begin
            miso_v[m][2*DW +: DW] = 32'h12345678;
            run_frame(m, 40, 72'({8'h83, 32'hDEADBEEF}), -1, 0);
            run_frame(m, 40, 72'({8'h02, 32'h0}), 20, 2);
        end

        run_frame(0, 28, 72'({8'h85, 20'hABCDE}), -1, 0);
        check("busy_after_abort", 64'(busy_v[0]), 64'd0);
        run_frame(0, 40, 72'({8'h85, 32'hCAFEF00D}), -1, 0);
        run_frame(0, 43, 72'({8'h86, 32'h13579BDF, 3'b101}), -1, 0);
        run_frame(1, 5, 72'(5'b10110), -1, 0);

        run_frame(4, 40, 72'({8'h8F, 32'hFEEDFACE}), -1, 0);
        run_frame(4, 40, 72'({8'h09, 32'h0}), -1, 0);
        run_frame(4, 40, 72'({8'h87, 32'hA5A5A5A5}), -1, 0);
        run_frame(4, 40, 72'({8'h07, 32'h0}), -1, 0);

`ifdef SPI_AUTOINC_EN
        run_frame(0, 72, {8'h8E, 32'h11111111, 32'h22222222}, -1, 0);
        run_frame(2, 72, {8'h0F, 32'h0, 32'h0}, -1, 0);
        run_frame(3, 56, {8'h0, 8'h91, 32'h33333333, 16'h4444}, -1, 0);
`endif

        for (int it = 0; it < 40; it++) begin
            g = $urandom_range(0, NI - 1);
            sel = $urandom_range(0, 5);
            nbits = (sel == 0) ? $urandom_range(1, 39) : (sel == 1) ? $urandom_range(41, 44) : 40;
            tx = {8'($urandom), 32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) miso_v[g][$urandom_range(0, 15)*DW +: DW] = $urandom;
            run_frame(g, nbits, tx, -1, 0);
        end

        q_rx.push_back('{inst: 0, bits: 72'd0});
        fork
            xfer(0, 40, 72'({8'h84, 32'h55AA55AA}), -1, 0);
            begin
                repeat (200) @(negedge clk);
                reset = 1'b1;
                for (int i = 0; i < NI; i++)
                    for (int w = 0; w < 16; w++) exp_mosi[i][w] = '0;
                repeat (2) @(negedge clk);
                for (int i = 0; i < NI; i++) check_idle_outputs("reset_mid_frame", i);
                reset = 1'b0;
            end
        join
        run_frame(0, 40, 72'({8'h84, 32'h0BADCAFE}), -1, 0);

        repeat (20) @(negedge clk);
        check("queues_drained", 64'(q_ev.size() + q_rx.size()), 64'd0);
        for (int i = 0; i < NI; i++)
            for (int w = 0; w < nreg(i); w++)
                check($sformatf("final_mosi_%0d_%0d", i, w), 64'(mosi_v[i][w*DW +: DW]), 64'(exp_mosi[i][w]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_regbank_slave.md
# spi_regbank_slave

Parametrised SPI slave register bank connecting the Raspberry Pi SPI master to the FPGA fabric. It generalises the fixed 40-bit, 16x32 register exchange to configurable data width, register counts and SPI mode (CPOL/CPHA). It adds per-access strobes, frame-error detection and an optional burst mode. It sits between the top-level SPI pins and the motor, encoder and laser logic: host writes land in `mosi_regs`, and status words are read from `miso_regs`.

## Interface
Parameters:
- `DATA_W`, 32: data word width in bits (8..32).
- `ADDR_W`, 4: register address width (1..7).
- `N_MOSI`, 16: number of host-writable registers (≤ 2^ADDR_W).
- `N_MISO`, 16: number of host-readable registers (≤ 2^ADDR_W).
- `CPOL`, 0: SPI clock idle level.
- `CPHA`, 0: 0 means sample on the leading edge; 1 means sample on the trailing edge.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; every flop runs on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `SPI_CLK`  in  1  SPI clock from the master; asynchronous to `clk`.
- `SPI_CS`  in  1  chip select, active-low; asynchronous.
- `SPI_MOSI`  in  1  master-out data; asynchronous.
- `SPI_MISO`  out  1  slave-out data; registered.
- `miso_regs`  in  N_MISO*DATA_W  flattened read registers; register i occupies bits [i*DATA_W +: DATA_W].
- `mosi_regs`  out  N_MOSI*DATA_W  flattened write registers, same packing.
- `wr_strobe`  out  1  one-cycle pulse when a MOSI register is written.
- `wr_addr`  out  ADDR_W  address of the last write; valid while `wr_strobe` is high.
- `rd_strobe`  out  1  one-cycle pulse when a MISO register is snapshotted.
- `rd_addr`  out  ADDR_W  address of the last snapshot.
- `busy`  out  1  high from CS fall detection until CS rise detection.
- `frame_err`  out  1  one-cycle pulse on a malformed frame.

## Operation
- Synchronisation: `SPI_CLK`, `SPI_CS` and `SPI_MOSI` each pass through a 2-flop synchroniser. Edges are detected from the 2nd and 3rd flop stages.
- Edge mapping: the leading edge is rising when CPOL=0 and falling when CPOL=1. With CPHA=0, sample on the leading edge and shift on the trailing edge; with CPHA=1, the reverse.
- Frame format, MSB first: 8-bit command byte, then DATA_W data bits.
  - Command bit 7: 1 = write, 0 = read.
  - Command bits [ADDR_W-1:0]: address. The remaining bits are ignored.
- FSM states:
  - IDLE: CS low -> CMD, with bit counter, shift register and MISO cleared.
  - CMD: 8 sample edges -> DATA, with address and direction latched.
  - DATA: DATA_W sample edges -> commit, then DONE.
  - DONE: wait for CS high.
  - A synchronised CS high in any state returns the FSM to IDLE on the next clk.
- Read: on the 8th sample edge, `miso_regs[addr]` is snapshotted into the shift register and `rd_strobe` pulses. The MSB drives `SPI_MISO` at the next shift edge; each later shift edge drives the next bit. During the command byte `SPI_MISO` is 0.
- Write: on the DATA_W-th data sample edge, the shifted word is written to `mosi_regs[addr]` and `wr_strobe` pulses.
- Out-of-range address: a write to addr ≥ N_MOSI is dropped, with no strobe. A read from addr ≥ N_MISO returns all zeros (`rd_strobe` still pulses).
- `frame_err` pulses when CS rises in CMD or DATA (partial frame, nothing committed), or when CS rises after sample edges beyond the frame while in DONE. Extra bits are ignored and `SPI_MISO` is 0 during them.

## Timing
- Reset values: `SPI_MISO`=0, `mosi_regs`=0, `wr_strobe`=0, `wr_addr`=0, `rd_strobe`=0, `rd_addr`=0, `busy`=0, `frame_err`=0, FSM in IDLE.
- Edge detection latency: 3 clk from a pin edge to the FSM action.
- `mosi_regs` update and `wr_strobe` occur in the same clk, 3 clk after the final sample edge.
- `SPI_MISO` changes 3–4 clk after a shift edge. Requirement: SPI_CLK period ≥ 8 clk periods, and CS setup/hold around SCLK edges ≥ 4 clk.
- `miso_regs` is sampled exactly once per word, at the snapshot. Later changes to `miso_regs` do not affect the word being shifted out.
- Reset asserted mid-frame: everything returns to reset values immediately. The remainder of the frame is ignored until CS goes high and then falls again.

## Configuration
- `SPI_AUTOINC_EN`: when defined, enables burst frames. After each committed or snapshotted word, the FSM returns to DATA with addr+1 (mod 2^ADDR_W). Further DATA_W-bit words then write or read consecutive registers, each with its own strobe.
  - In burst mode, CS rising mid-word raises `frame_err` and discards only the partial word.
  - When not defined, exactly one word per frame, as described under Operation.

## Test plan
- Mode 0, DATA_W=32: host sends 0x83 then 0xDEADBEEF -> `mosi_regs[3]`=0xDEADBEEF, one `wr_strobe` with `wr_addr`=3; no other register changes.
- Mode 0: `miso_regs[2]`=0x12345678, host sends 0x02 plus 32 clocks -> MISO returns 0x12345678 MSB first; `rd_strobe` pulses once with `rd_addr`=2. `miso_regs[2]` changed to 0 mid-word -> MISO still returns 0x12345678.
- Modes 1, 2 and 3: repeat both transfers above -> identical register and MISO results.
- CS raised after 20 bits of a write to addr 5 -> `mosi_regs[5]` unchanged, `frame_err` pulses once, `busy` falls; the next full frame succeeds.
- Write to addr 0x0F with N_MOSI=8 -> no write and no strobe; read of addr 9 with N_MISO=8 -> MISO returns 0x00000000.
- `SPI_AUTOINC_EN`: host sends 0x8E then 0x11111111 and 0x22222222 -> `mosi_regs[14]`=0x11111111, `mosi_regs[15]`=0x22222222, two `wr_strobe` pulses. Reset asserted mid-frame -> all outputs are 0 and no write occurs.
